// File: rtl/quad_bank.sv
// -----------------------------------------------------------------------------
// quad_bank
//   Bank of NCH quadrature decoders sharing one free-running timestamp.
//   Each channel synchronises its A/B pins, glitch-filters them, decodes
//   the filtered Gray sequence into a wrapping up/down count and flags
//   illegal (two-bit) transitions. A snapshot request copies the timestamp
//   and every counter into one packed word.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   quad_a     [NCH]  channel A pins (asynchronous)
//   quad_b     [NCH]  channel B pins (asynchronous)
//   dir_inv    [NCH]  swap count direction per channel (static)
//   clr        [NCH]  per-channel counter clear pulse
//   snap       capture request pulse
//   err_clr    clear all sticky error flags
//   snap_data  [TW+NCH*CW] {time, ch0, ch1, ... ch(NCH-1)}, MSB first
//   snap_valid one-cycle pulse the cycle after a capture
//   err        [NCH]  sticky illegal-transition flags
//
//   snap/snap_valid is a fire-and-forget strobe pair: there is no ready,
//   every snap pulse is accepted and answered by exactly one snap_valid
//   pulse on the next cycle.
// -----------------------------------------------------------------------------
module quad_bank #(
  parameter int NCH   = 10,
  parameter int CW    = 32,
  parameter int TW    = 32,
  parameter int FILT  = 3,
  parameter int PRESC = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         quad_a,
  input  logic [NCH-1:0]         quad_b,
  input  logic [NCH-1:0]         dir_inv,
  input  logic [NCH-1:0]         clr,
  input  logic                   snap,
  input  logic                   err_clr,
  output logic [TW+NCH*CW-1:0]   snap_data,
  output logic                   snap_valid,
  output logic [NCH-1:0]         err
);

  localparam int RW = 4;
  localparam int SW = TW + NCH * CW;
  localparam logic [RW-1:0] RUN_LAST   = RW'(FILT - 1);
  localparam logic [7:0]    PRESC_LAST = 8'(PRESC - 1);

  // One filtered pin: current filtered value, whether it has ever
  // qualified since reset, and the length of the current disagreement run.
  typedef struct packed {
    logic          val;
    logic          qual;
    logic [RW-1:0] run;
  } filt_t;

  // Before the first qualification the filter tracks a candidate value and
  // waits for FILT stable samples of it; afterwards it only moves to a new
  // value once the synchronised pin has disagreed for FILT consecutive clocks.
  function automatic filt_t filt_step(input filt_t cur, input logic s,
                                      input logic live);
    filt_t nxt;
    nxt = cur;
    if (!live) begin
      nxt = cur;
    end else if (!cur.qual) begin
      if (s != cur.val) begin
        nxt.val = s;
        nxt.run = '0;
      end else if (cur.run == RUN_LAST) begin
        nxt.qual = 1'b1;
        nxt.run  = '0;
      end else begin
        nxt.run = cur.run + RW'(1);
      end
    end else if (s != cur.val) begin
      if (cur.run == RUN_LAST) begin
        nxt.val = s;
        nxt.run = '0;
      end else begin
        nxt.run = cur.run + RW'(1);
      end
    end else begin
      nxt.run = '0;
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. warm marks when the second stage holds real pin
  // data after reset, so the filters never qualify on the reset zeros.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] a_s1, a_s2, b_s1, b_s2;
  logic [1:0]     warm;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1 <= '0;
      a_s2 <= '0;
      b_s1 <= '0;
      b_s2 <= '0;
      warm <= '0;
    end else begin
      a_s1 <= quad_a;
      a_s2 <= a_s1;
      b_s1 <= quad_b;
      b_s2 <= b_s1;
      warm <= {warm[0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and timestamp
  // ---------------------------------------------------------------------------
  logic [7:0]    presc;
  logic [TW-1:0] tstamp;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      tstamp <= '0;
    end else if (presc == PRESC_LAST) begin
      presc  <= '0;
      tstamp <= tstamp + TW'(1);
    end else begin
      presc  <= presc + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel filter, decoder and counter
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_w [NCH];
  logic          err_w [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    filt_t         fa, fb;
    logic          primed;
    logic [1:0]    prev;
    logic [CW-1:0] cnt;
    logic          err_r;
    logic [1:0]    ab_now, pos_now, pos_old, step;
    logic          moved, illegal, up;

    // Map {a,b} onto its position in the forward cycle 00,10,11,01 so that
    // a forward step is +1 mod 4, a reverse step is -1 and a jump of 2 is
    // a two-bit (illegal) change.
    always_comb begin
      ab_now  = {fa.val, fb.val};
      pos_now = {ab_now[0], ab_now[1] ^ ab_now[0]};
      pos_old = {prev[0], prev[1] ^ prev[0]};
      step    = pos_now - pos_old;
      moved   = primed && (step != 2'd0);
      illegal = primed && (step == 2'd2);
      up      = (step == 2'd1) ^ dir_inv[i];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        fa     <= '0;
        fb     <= '0;
        primed <= 1'b0;
        prev   <= '0;
        cnt    <= '0;
        err_r  <= 1'b0;
      end else begin
        fa <= filt_step(fa, a_s2[i], warm[1]);
        fb <= filt_step(fb, b_s2[i], warm[1]);

        // The first fully qualified state only seeds prev.
        if (primed || (fa.qual && fb.qual)) begin
          prev   <= ab_now;
          primed <= 1'b1;
        end

        if (clr[i]) begin
          cnt <= '0;
        end else if (moved && !illegal) begin
          cnt <= up ? cnt + CW'(1) : cnt - CW'(1);
        end

        if (illegal) begin
          err_r <= 1'b1;
        end else if (err_clr) begin
          err_r <= 1'b0;
        end
      end
    end

    assign cnt_w[i] = cnt;
    assign err_w[i] = err_r;
  end

  always_comb begin
    err = '0;
    for (int i = 0; i < NCH; i++) begin
      err[i] = err_w[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot: registers sample pre-edge values, so a clear or count landing
  // on the snap edge is not visible in that snapshot.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] snap_word;

  always_comb begin
    snap_word = '0;
    snap_word[SW-1 -: TW] = tstamp;
    for (int i = 0; i < NCH; i++) begin
      snap_word[(NCH-1-i)*CW +: CW] = cnt_w[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_data  <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap;
      if (snap) begin
        snap_data <= snap_word;
      end
    end
  end

endmodule

// File: tb/tb_quad_bank.sv
// -----------------------------------------------------------------------------
// tb_quad_bank
//   Self-checking bench for quad_bank with default parameters. A behavioural
//   model keeps, per channel, the last settled {a,b}, an integer count and a
//   sticky error bit; expected snapshots are queued in exp_q and compared when
//   snap_valid returns. All driving and sampling happens on the falling edge.
// -----------------------------------------------------------------------------
module tb_quad_bank;
  localparam int NCH   = 10;
  localparam int CW    = 32;
  localparam int TW    = 32;
  localparam int FILT  = 3;
  localparam int PRESC = 25;
  localparam int SW    = TW + NCH * CW;

  // ---------------------------------------------------------------- clock/reset
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] quad_a = '0;
  logic [NCH-1:0] quad_b = '0;
  logic [NCH-1:0] dir_inv = '0;
  logic [NCH-1:0] clr = '0;
  logic           snap = 1'b0;
  logic           err_clr = 1'b0;
  logic [SW-1:0]  snap_data;
  logic           snap_valid;
  logic [NCH-1:0] err;

  always #5 clk = ~clk;

  quad_bank #(
    .NCH(NCH), .CW(CW), .TW(TW), .FILT(FILT), .PRESC(PRESC)
  ) dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b),
    .dir_inv(dir_inv), .clr(clr), .snap(snap), .err_clr(err_clr),
    .snap_data(snap_data), .snap_valid(snap_valid), .err(err)
  );

  // Rising edges since reset release; at a falling edge this is the count
  // that the next rising edge sees as "before the edge".
  int edges = 0;
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] last_snap;

  logic [CW-1:0]  m_cnt [NCH];
  logic [1:0]     m_ab  [NCH];
  logic [NCH-1:0] m_err;
  logic [1:0]     fwd_seq [4];

  task automatic check(input string name, input logic [SW-1:0] act,
                       input logic [SW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic int pos_of(input logic [1:0] ab);
    for (int k = 0; k < 4; k++) if (fwd_seq[k] == ab) return k;
    return 0;
  endfunction

  function automatic logic [1:0] nbr(input int ch, input int off);
    return fwd_seq[(pos_of(m_ab[ch]) + off) % 4];
  endfunction

  function automatic logic [CW-1:0] ch_field(input logic [SW-1:0] d, input int ch);
    return d[(NCH-1-ch)*CW +: CW];
  endfunction

  function automatic logic [SW-1:0] build_exp();
    logic [SW-1:0] e;
    e = '0;
    e[SW-1 -: TW] = TW'(edges / PRESC);
    for (int ch = 0; ch < NCH; ch++) e[(NCH-1-ch)*CW +: CW] = m_cnt[ch];
    return e;
  endfunction

  // ---------------------------------------------------------------- drivers
  // Drive a channel's pins to a new state and advance the model by the rule:
  // position difference in the forward cycle 1 -> +1, 3 -> -1, 2 -> error.
  task automatic move(input int ch, input logic [1:0] ab);
    int d;
    quad_a[ch] = ab[1];
    quad_b[ch] = ab[0];
    d = (pos_of(ab) - pos_of(m_ab[ch]) + 4) % 4;
    if (d == 2) m_err[ch] = 1'b1;
    else if (d != 0) begin
      if ((d == 1) != dir_inv[ch]) m_cnt[ch] = m_cnt[ch] + CW'(1);
      else                         m_cnt[ch] = m_cnt[ch] - CW'(1);
    end
    m_ab[ch] = ab;
  endtask

  task automatic apply_reset(input logic [1:0] ab);
    @(negedge clk);
    rst = 1'b1; snap = 1'b0; clr = '0; err_clr = 1'b0; dir_inv = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      quad_a[ch] = ab[1];
      quad_b[ch] = ab[0];
    end
    repeat (3) @(negedge clk);
    check("rst_snap_valid", SW'(snap_valid), SW'(1'b0));
    check("rst_snap_data", snap_data, '0);
    check("rst_err", SW'(err), '0);
    rst = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_cnt[ch] = '0;
      m_ab[ch]  = ab;
    end
    m_err = '0;
    repeat (12) @(negedge clk);
  endtask

  // Called at a falling edge with everything settled.
  task automatic snap_check();
    exp_q.push_back(build_exp());
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    last_snap = snap_data;
    check("snap_valid", SW'(snap_valid), SW'(1'b1));
    if (exp_q.size() > 0) check("snap_data", snap_data, exp_q.pop_front());
    check("err", SW'(err), SW'(m_err));
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int            ch;
    logic [1:0]    ab;
    logic          inv;
    logic          do_clr;
    logic          do_errclr;
    logic [CW-1:0] exp_cnt;
    logic          exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // ---------------------------------------------------------------- test
  initial begin
    logic [NCH-1:0] moved_m;
    int r, gch, glen, gbit, c;
    logic do_glitch;

    fwd_seq = '{2'b00, 2'b10, 2'b11, 2'b01};

    vecs[0]  = '{1, 2'b01, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{1, 2'b11, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{1, 2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h1,         1'b0};
    vecs[5]  = '{1, 2'b11, 1'b1, 1'b0, 1'b0, 32'h2,         1'b0};
    vecs[6]  = '{1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h3,         1'b0};
    vecs[7]  = '{2, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[8]  = '{2, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[9]  = '{2, 2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{2, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{4, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1,         1'b0};
    vecs[12] = '{4, 2'b11, 1'b0, 1'b0, 1'b0, 32'h2,         1'b0};
    vecs[13] = '{4, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1,         1'b0};

    // Reset released with all pins high: no counts, no errors.
    apply_reset(2'b11);
    repeat (10) @(negedge clk);
    check("pins_high_err", SW'(err), '0);
    snap_check();
    check("pins_high_cnt", SW'(last_snap[NCH*CW-1:0]), '0);

    // Snapshot 250 clocks after reset with ch0 at 5.
    apply_reset(2'b00);
    repeat (5) begin
      move(0, nbr(0, 1));
      repeat (8) @(negedge clk);
    end
    while (edges < 250) @(negedge clk);
    exp_q.push_back(build_exp());
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    check("snap250_valid", SW'(snap_valid), SW'(1'b1));
    check("snap250_time", SW'(snap_data[SW-1 -: TW]), SW'(10));
    check("snap250_ch0", SW'(ch_field(snap_data, 0)), SW'(5));
    check("snap250_data", snap_data, exp_q.pop_front());
    @(negedge clk);
    check("snap_valid_drop", SW'(snap_valid), SW'(1'b0));

    // Forward rotation on ch0 with back-to-back snaps around the first update.
    apply_reset(2'b00);
    move(0, 2'b10);
    snap = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("lat_valid", SW'(snap_valid), SW'(1'b1));
      check("lat_ch0", SW'(ch_field(snap_data, 0)), SW'((k >= 7) ? 1 : 0));
    end
    snap = 1'b0;
    for (int s = 1; s < 40; s++) begin
      move(0, nbr(0, 1));
      repeat (8) @(negedge clk);
    end
    snap_check();
    check("fwd40_ch0", SW'(ch_field(last_snap, 0)), SW'(40));

    // Table of single steps, clears and error clears.
    apply_reset(2'b00);
    for (int v = 0; v < NV; v++) begin
      dir_inv[vecs[v].ch] = vecs[v].inv;
      if (vecs[v].ab != m_ab[vecs[v].ch]) move(vecs[v].ch, vecs[v].ab);
      repeat (8) @(negedge clk);
      if (vecs[v].do_clr) begin
        clr[vecs[v].ch] = 1'b1;
        m_cnt[vecs[v].ch] = '0;
        @(negedge clk);
        clr = '0;
      end
      if (vecs[v].do_errclr) begin
        err_clr = 1'b1;
        m_err = '0;
        @(negedge clk);
        err_clr = 1'b0;
      end
      @(negedge clk);
      snap_check();
      check("vec_cnt", SW'(ch_field(last_snap, vecs[v].ch)), SW'(vecs[v].exp_cnt));
      check("vec_err", SW'(err[vecs[v].ch]), SW'(vecs[v].exp_err));
    end

    // 2-clock glitch on ch2 A is rejected.
    quad_a[2] = ~m_ab[2][1];
    repeat (2) @(negedge clk);
    quad_a[2] = m_ab[2][1];
    repeat (10) @(negedge clk);
    snap_check();

    // Illegal transition on ch2 colliding with err_clr keeps the flag.
    move(2, nbr(2, 2));
    repeat (5) @(negedge clk);
    check("err_not_yet", SW'(err[2]), SW'(1'b0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_priority", SW'(err[2]), SW'(1'b1));
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    m_err = '0;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", SW'(err), '0);

    // clr[3] on the count-update edge, with a snap in the same cycle.
    move(3, nbr(3, 1));
    repeat (8) @(negedge clk);
    move(3, nbr(3, 1));
    repeat (5) @(negedge clk);
    clr[3] = 1'b1;
    snap = 1'b1;
    @(negedge clk);
    clr = '0;
    snap = 1'b0;
    m_cnt[3] = '0;
    check("clr_snap_valid", SW'(snap_valid), SW'(1'b1));
    check("clr_snap_pre", SW'(ch_field(snap_data, 3)), SW'(1));
    repeat (3) @(negedge clk);
    snap_check();
    check("clr_collision", SW'(ch_field(last_snap, 3)), '0);

    // Randomised steps on all channels against the model.
    dir_inv = NCH'($urandom());
    for (int it = 0; it < 150; it++) begin
      moved_m = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        r = $urandom_range(0, 19);
        if (r >= 10 && r < 15)      begin move(ch, nbr(ch, 1)); moved_m[ch] = 1'b1; end
        else if (r >= 15 && r < 18) begin move(ch, nbr(ch, 3)); moved_m[ch] = 1'b1; end
        else if (r >= 18)           begin move(ch, nbr(ch, 2)); moved_m[ch] = 1'b1; end
      end
      gch  = $urandom_range(0, NCH-1);
      glen = $urandom_range(1, 2);
      gbit = $urandom_range(0, 1);
      do_glitch = !moved_m[gch] && ($urandom_range(0, 3) == 0);
      if (do_glitch) begin
        if (gbit == 1) quad_a[gch] = ~m_ab[gch][1];
        else           quad_b[gch] = ~m_ab[gch][0];
      end
      for (int w = 1; w <= 8; w++) begin
        @(negedge clk);
        if (do_glitch && w == glen) begin
          quad_a[gch] = m_ab[gch][1];
          quad_b[gch] = m_ab[gch][0];
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(0, NCH-1);
        clr[c] = 1'b1;
        m_cnt[c] = '0;
        @(negedge clk);
        clr = '0;
      end
      if ($urandom_range(0, 9) == 0) begin
        err_clr = 1'b1;
        m_err = '0;
        @(negedge clk);
        err_clr = 1'b0;
      end
      snap_check();
    end

    @(negedge clk);
    check("snap_valid_idle", SW'(snap_valid), SW'(1'b0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
